// File: rtl/log2_lut_pipe.sv
// Two-stage pipelined log2(1.f) mantissa lookup with valid/ready handshake and sideband tag.
// Optional build macro LOG2_LUT_PIPE_STATS_EN adds saturating accept/stall counters.
module log2_lut_pipe #(
    parameter int unsigned IN  = 8,
    parameter int unsigned OUT = 4,
    parameter int unsigned TAG = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IN-1:0]  in_data,
    input  logic [TAG-1:0] in_tag,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OUT:0]   out_data,
    output logic [TAG-1:0] out_tag
`ifdef LOG2_LUT_PIPE_STATS_EN
    ,
    output logic [31:0]    stat_accept,
    output logic [31:0]    stat_stall
`endif
);

    localparam int unsigned DEPTH = 2 ** IN;
    localparam int unsigned RW    = OUT + 1;
    // Fixed-point precision of the elaboration-time log2; far above any legal IN/OUT.
    localparam int unsigned FP    = 60;

    // Bit-serial log2 by repeated squaring of y = 1.f; one extra bit is kept for round-half-up.
    function automatic logic [OUT:0] log2_entry(input int unsigned idx);
        logic [127:0] y;
        logic [31:0]  r;
        y = 128'(DEPTH + idx) << (FP - IN);
        r = 32'd0;
        for (int unsigned k = 0; k < RW; k++) begin
            y = (y * y) >> FP;
            r = {r[30:0], 1'b0};
            if (y >= (128'd1 << (FP + 1))) begin
                r[0] = 1'b1;
                y    = y >> 1;
            end
        end
        return RW'((r + 32'd1) >> 1);
    endfunction

    logic [OUT:0] lut [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lut
        localparam logic [OUT:0] ENTRY = log2_entry(gi);
        assign lut[gi] = ENTRY;
    end

    logic           s1_v_q,    s1_v_d;
    logic [IN-1:0]  s1_data_q, s1_data_d;
    logic [TAG-1:0] s1_tag_q,  s1_tag_d;
    logic           s2_v_q,    s2_v_d;
    logic [OUT:0]   s2_data_q, s2_data_d;
    logic [TAG-1:0] s2_tag_q,  s2_tag_d;

    logic s2_adv_c;
    logic in_ready_c;
    logic accept_c;

    // Advance/handshake decisions and next-state of both stages.
    always_comb begin
        s2_adv_c   = s1_v_q && (!s2_v_q || out_ready);
        in_ready_c = !s1_v_q || s2_adv_c;
        accept_c   = in_valid && in_ready_c;

        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s1_tag_d  = s1_tag_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_tag_d  = s2_tag_q;

        if (accept_c) begin
            s1_v_d    = 1'b1;
            s1_data_d = in_data;
            s1_tag_d  = in_tag;
        end else if (s2_adv_c) begin
            s1_v_d = 1'b0;
        end

        if (s2_adv_c) begin
            s2_v_d    = 1'b1;
            s2_data_d = lut[s1_data_q];
            s2_tag_d  = s1_tag_q;
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_tag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_tag_q  <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_tag_q  <= s1_tag_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_tag_q  <= s2_tag_d;
        end
    end

    // in_ready is combinational from out_ready by design; out_* come straight from S2 flops.
    assign in_ready  = in_ready_c;
    assign out_valid = s2_v_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;

`ifdef LOG2_LUT_PIPE_STATS_EN
    logic [31:0] stat_accept_q, stat_accept_d;
    logic [31:0] stat_stall_q,  stat_stall_d;

    // Saturating event counters.
    always_comb begin
        stat_accept_d = stat_accept_q;
        stat_stall_d  = stat_stall_q;
        if (accept_c && (stat_accept_q != 32'hFFFF_FFFF)) begin
            stat_accept_d = stat_accept_q + 32'd1;
        end
        if (s2_v_q && !out_ready && (stat_stall_q != 32'hFFFF_FFFF)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_accept_q <= 32'd0;
            stat_stall_q  <= 32'd0;
        end else begin
            stat_accept_q <= stat_accept_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_accept = stat_accept_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_log2_lut_pipe.sv
// Self-checking bench for log2_lut_pipe: real-math scoreboard plus directed literal vectors.
module tb_log2_lut_pipe;

    localparam int unsigned IN  = 8;
    localparam int unsigned OUT = 4;
    localparam int unsigned TAG = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [IN-1:0]  in_data;
    logic [TAG-1:0] in_tag;
    logic           out_valid;
    logic           out_ready;
    logic [OUT:0]   out_data;
    logic [TAG-1:0] out_tag;

    logic           in5_valid;
    logic           in5_ready;
    logic [4:0]     in5_data;
    logic [TAG-1:0] in5_tag;
    logic           out5_valid;
    logic           out5_ready;
    logic [OUT:0]   out5_data;
    logic [TAG-1:0] out5_tag;

`ifdef LOG2_LUT_PIPE_STATS_EN
    logic [31:0] stat_accept, stat_stall, stat5_accept, stat5_stall;
`endif

    always #5 clock = ~clock;

    log2_lut_pipe #(.IN(IN), .OUT(OUT), .TAG(TAG)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef LOG2_LUT_PIPE_STATS_EN
        ,
        .stat_accept (stat_accept),
        .stat_stall  (stat_stall)
`endif
    );

    log2_lut_pipe #(.IN(5), .OUT(OUT), .TAG(TAG)) u_dut5 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in5_valid),
        .in_ready  (in5_ready),
        .in_data   (in5_data),
        .in_tag    (in5_tag),
        .out_valid (out5_valid),
        .out_ready (out5_ready),
        .out_data  (out5_data),
        .out_tag   (out5_tag)
`ifdef LOG2_LUT_PIPE_STATS_EN
        ,
        .stat_accept (stat5_accept),
        .stat_stall  (stat5_stall)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int exp_d[$];
    int exp_t[$];
    int n_acc   = 0;
    int n_pop   = 0;
    int n_stall = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: round-half-up of log2(1 + idx/2**in_w) scaled by 2**out_w, in real arithmetic.
    function automatic int model(input int idx, input int in_w, input int out_w);
        real x;
        x = 1.0 + real'(idx) / (2.0 ** in_w);
        return int'($floor($ln(x) / $ln(2.0) * (2.0 ** out_w) + 0.5));
    endfunction

    // Scoreboard: push at input handshake, pop and compare at output handshake, check hold while stalled.
    task automatic monitor();
        logic hv;
        int   hd;
        int   ht;
        int   ed;
        int   et;
        hv = 1'b0;
        hd = 0;
        ht = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_d.delete();
                exp_t.delete();
                n_acc   = 0;
                n_stall = 0;
                hv      = 1'b0;
            end else begin
                if (hv) begin
                    chk("hold_valid", int'(out_valid), 1);
                    chk("hold_data", int'(out_data), hd);
                    chk("hold_tag", int'(out_tag), ht);
                end
                if (out_valid && out_ready) begin
                    n_chk++;
                    if (exp_d.size() == 0) begin
                        n_fail++;
                        $display("FAIL spurious_out: got data %0d with no beat outstanding (t=%0t)",
                                 out_data, $time);
                    end else begin
                        ed = exp_d.pop_front();
                        et = exp_t.pop_front();
                        n_pop++;
                        if ((int'(out_data) != ed) || (int'(out_tag) != et)) begin
                            n_fail++;
                            $display("FAIL sb_beat: got data %0d tag %0d, expected data %0d tag %0d (t=%0t)",
                                     out_data, out_tag, ed, et, $time);
                        end
                    end
                end
                if (out_valid && !out_ready) n_stall++;
                hv = out_valid && !out_ready;
                hd = int'(out_data);
                ht = int'(out_tag);
                if (in_valid && in_ready) begin
                    exp_d.push_back(model(int'(in_data), IN, OUT));
                    exp_t.push_back(int'(in_tag));
                    n_acc++;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t1_in  [4];
        int t1_exp [4];
        int p0;
        int target;
        int cyc;
`ifdef LOG2_LUT_PIPE_STATS_EN
        int stall0;
        int acc0;
`endif
        t1_in  = '{0, 'h40, 'h80, 'hFF};
        t1_exp = '{0, 5, 9, 16};

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_tag     = '0;
        out_ready  = 1'b0;
        in5_valid  = 1'b0;
        in5_data   = '0;
        in5_tag    = '0;
        out5_ready = 1'b1;

        fork
            monitor();
        join_none

        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_tag", int'(out_tag), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        chk("model_00", model(0, 8, 4), 0);
        chk("model_40", model('h40, 8, 4), 5);
        chk("model_80", model('h80, 8, 4), 9);
        chk("model_ff", model('hFF, 8, 4), 16);
        chk("model_in5_10", model('h10, 5, 4), 9);
        reset = 1'b0;

        // Single beats with literal expectations and two-cycle latency.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = IN'(t1_in[k]);
            in_tag   = TAG'(k + 3);
            if (k == 0) begin
                in5_valid = 1'b1;
                in5_data  = 5'h10;
                in5_tag   = 4'hA;
            end
            @(posedge clock);
            #1;
            in_valid  = 1'b0;
            in5_valid = 1'b0;
            chk("t1_lat1_valid", int'(out_valid), 0);
            @(posedge clock);
            #1;
            chk("t1_valid", int'(out_valid), 1);
            chk("t1_data", int'(out_data), t1_exp[k]);
            chk("t1_tag", int'(out_tag), k + 3);
            if (k == 0) begin
                chk("t6_in5_valid", int'(out5_valid), 1);
                chk("t6_in5_data", int'(out5_data), 9);
                chk("t6_in5_tag", int'(out5_tag), 'hA);
            end
        end
        @(posedge clock);
        #1;

        // Full-table stream, no bubbles allowed.
        p0 = n_pop;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = IN'(i);
            in_tag   = TAG'(i);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("t2_results_in_window", n_pop - p0, 256);
        @(posedge clock);
        #1;

        // Backpressure: two accepts then full, five stalled cycles, then drain.
`ifdef LOG2_LUT_PIPE_STATS_EN
        stall0 = int'(stat_stall);
`endif
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h10;
        in_tag    = 4'h1;
        @(posedge clock);
        #1;
        chk("t3_ready_after_1", int'(in_ready), 1);
        in_data = 8'h20;
        in_tag  = 4'h2;
        @(posedge clock);
        #1;
        in_data = 8'h30;
        in_tag  = 4'h3;
        chk("t3_full_in_ready", int'(in_ready), 0);
        chk("t3_full_out_valid", int'(out_valid), 1);
        chk("t3_full_out_data", int'(out_data), model('h10, 8, 4));
        for (int s = 0; s < 5; s++) begin
            @(posedge clock);
            #1;
            chk("t3_stall_in_ready", int'(in_ready), 0);
        end
`ifdef LOG2_LUT_PIPE_STATS_EN
        chk("t3_stat_stall", int'(stat_stall) - stall0, 5);
`endif
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (exp_d.size() == 0 && !out_valid) break;
            @(posedge clock);
            #1;
        end
        chk("t3_drained", exp_d.size(), 0);
        chk("t3_empty_valid", int'(out_valid), 0);

        // Random valid/ready at 50%.
        target = n_acc + 10000;
        cyc    = 0;
        while (n_acc < target && cyc < 60000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = IN'($urandom);
            in_tag    = TAG'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            cyc++;
        end
        chk("t4_accepted", n_acc - (target - 10000), 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int w = 0; w < 20; w++) begin
            if (exp_d.size() == 0 && !out_valid) break;
            @(posedge clock);
            #1;
        end
        chk("t4_drained", exp_d.size(), 0);

`ifdef LOG2_LUT_PIPE_STATS_EN
        chk("stat_accept_total", int'(stat_accept), n_acc);
        chk("stat_stall_total", int'(stat_stall), n_stall);
        chk("stat5_accept", int'(stat5_accept), 1);
`endif

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        in_tag    = 4'h1;
        @(posedge clock);
        #1;
        in_data = 8'h22;
        in_tag  = 4'h2;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("t5_full_valid", int'(out_valid), 1);
        chk("t5_full_in_ready", int'(in_ready), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_out_data", int'(out_data), 0);
        chk("t5_rst_out_tag", int'(out_tag), 0);
`ifdef LOG2_LUT_PIPE_STATS_EN
        chk("t5_rst_stat_accept", int'(stat_accept), 0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("t5_rel_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h80;
        in_tag    = 4'h5;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("t5_lat1_valid", int'(out_valid), 0);
        @(posedge clock);
        #1;
        chk("t5_new_valid", int'(out_valid), 1);
        chk("t5_new_data", int'(out_data), 9);
        chk("t5_new_tag", int'(out_tag), 5);
        @(posedge clock);
        #1;
        chk("t5_drained", exp_d.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
